// File: rtl/ps2_jump_scheduler.sv
// rtl/ps2_jump_scheduler.sv - PS/2 scancode prefix FSM with held-key tracking and jump/start/duck scheduling
// Optional build macro: PS2_AUTO_REPEAT_EN (periodic jump reissue while UP/SPACE held)
module ps2_jump_scheduler #(
  parameter logic [7:0] UP_CODE        = 8'h75,
  parameter logic [7:0] DOWN_CODE      = 8'h72,
  parameter logic [7:0] SPACE_CODE     = 8'h29,
  parameter int         PREFIX_TIMEOUT = 50000,
  parameter int         REPEAT_CYCLES  = 12500000
) (
  input  logic       CLOCK_50,
  input  logic       reset,
  input  logic [7:0] ps2_key_data,
  input  logic       ps2_key_pressed,
  input  logic       game_over,
  output logic       jump_pulse,
  output logic       start_pulse,
  output logic       duck_held,
  output logic       up_held,
  output logic       space_held,
  output logic       prefix_timeout,
  output logic [1:0] state_dbg
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    EXT     = 2'd1,
    BRK     = 2'd2,
    EXT_BRK = 2'd3
  } state_t;

  localparam int CW = (PREFIX_TIMEOUT > 2) ? $clog2(PREFIX_TIMEOUT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(PREFIX_TIMEOUT - 1);

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          up_q, up_d;
  logic          down_q, down_d;
  logic          space_q, space_d;
  logic          duck_q, duck_d;
  logic          jump_q, jump_d;
  logic          start_q, start_d;
  logic          pt_q, pt_d;

  logic is_make, is_brk, ext;
  logic hit_up, hit_down, hit_space;
  logic rising;
  logic repeat_fire;

  assign hit_up    = (ps2_key_data == UP_CODE);
  assign hit_down  = (ps2_key_data == DOWN_CODE);
  assign hit_space = (ps2_key_data == SPACE_CODE) && !ext;

  always_comb begin
    state_d = state_q;
    cnt_d   = '0;
    pt_d    = 1'b0;
    is_make = 1'b0;
    is_brk  = 1'b0;
    ext     = 1'b0;
    if (ps2_key_pressed) begin
      case (state_q)
        IDLE: begin
          if (ps2_key_data == 8'hE0)      state_d = EXT;
          else if (ps2_key_data == 8'hF0) state_d = BRK;
          else                            is_make = 1'b1;
        end
        EXT: begin
          if (ps2_key_data == 8'hF0)      state_d = EXT_BRK;
          else if (ps2_key_data == 8'hE0) state_d = EXT;
          else begin
            is_make = 1'b1;
            ext     = 1'b1;
            state_d = IDLE;
          end
        end
        BRK: begin
          is_brk  = 1'b1;
          state_d = IDLE;
        end
        default: begin
          is_brk  = 1'b1;
          ext     = 1'b1;
          state_d = IDLE;
        end
      endcase
    end else if (state_q != IDLE) begin
      // A strobe in the would-be timeout cycle takes the branch above instead.
      if (cnt_q == CNT_LAST) begin
        state_d = IDLE;
        pt_d    = 1'b1;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  always_comb begin
    up_d    = up_q;
    down_d  = down_q;
    space_d = space_q;
    if (is_make) begin
      if (hit_up)    up_d    = 1'b1;
      if (hit_down)  down_d  = 1'b1;
      if (hit_space) space_d = 1'b1;
    end else if (is_brk) begin
      if (hit_up)    up_d    = 1'b0;
      if (hit_down)  down_d  = 1'b0;
      if (hit_space) space_d = 1'b0;
    end
    duck_d = down_d && !up_d && !space_d;
  end

  assign rising  = is_make && ((hit_up && !up_q) || (hit_space && !space_q));
  assign jump_d  = (rising && !game_over) || repeat_fire;
  assign start_d = rising && game_over;

`ifdef PS2_AUTO_REPEAT_EN
  localparam int RW = (REPEAT_CYCLES > 2) ? $clog2(REPEAT_CYCLES) : 1;
  localparam logic [RW-1:0] REP_LAST = RW'(REPEAT_CYCLES - 1);

  logic [RW-1:0] rep_q, rep_d;

  always_comb begin
    rep_d       = '0;
    repeat_fire = 1'b0;
    // A rising make leaves rep_d at zero, restarting the period.
    if ((up_q || space_q) && !game_over && !rising) begin
      if (rep_q == REP_LAST) repeat_fire = 1'b1;
      else                   rep_d = rep_q + RW'(1);
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) rep_q <= '0;
    else       rep_q <= rep_d;
  end
`else
  // Folds to constant 0; no repeat counter exists in this build.
  assign repeat_fire = (REPEAT_CYCLES < 0);
`endif

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      up_q    <= 1'b0;
      down_q  <= 1'b0;
      space_q <= 1'b0;
      duck_q  <= 1'b0;
      jump_q  <= 1'b0;
      start_q <= 1'b0;
      pt_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      up_q    <= up_d;
      down_q  <= down_d;
      space_q <= space_d;
      duck_q  <= duck_d;
      jump_q  <= jump_d;
      start_q <= start_d;
      pt_q    <= pt_d;
    end
  end

  assign jump_pulse     = jump_q;
  assign start_pulse    = start_q;
  assign duck_held      = duck_q;
  assign up_held        = up_q;
  assign space_held     = space_q;
  assign prefix_timeout = pt_q;
  assign state_dbg      = state_q;

endmodule

// File: tb/tb_ps2_jump_scheduler.sv
// tb/tb_ps2_jump_scheduler.sv - directed self-checking bench for ps2_jump_scheduler
module tb_ps2_jump_scheduler;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] ps2_key_data;
  logic       ps2_key_pressed;
  logic       game_over;
  logic       jump_pulse, start_pulse, duck_held, up_held, space_held, prefix_timeout;
  logic [1:0] state_dbg;

  int n_checks = 0;
  int n_pass   = 0;

  always #10 clk = ~clk;

  ps2_jump_scheduler #(.PREFIX_TIMEOUT(16)) dut (
    .CLOCK_50       (clk),
    .reset          (reset),
    .ps2_key_data   (ps2_key_data),
    .ps2_key_pressed(ps2_key_pressed),
    .game_over      (game_over),
    .jump_pulse     (jump_pulse),
    .start_pulse    (start_pulse),
    .duck_held      (duck_held),
    .up_held        (up_held),
    .space_held     (space_held),
    .prefix_timeout (prefix_timeout),
    .state_dbg      (state_dbg)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  // Strobe held across one rising edge; returns at the next falling edge with outputs updated.
  task automatic send(input logic [7:0] b);
    @(negedge clk);
    ps2_key_data    = b;
    ps2_key_pressed = 1'b1;
    @(negedge clk);
    ps2_key_pressed = 1'b0;
  endtask

  task automatic idle_cycle();
    @(negedge clk);
  endtask

  initial begin
    reset           = 1'b1;
    ps2_key_data    = 8'h00;
    ps2_key_pressed = 1'b0;
    game_over       = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;

    check("rst_state", state_dbg, 0);
    check("rst_up", up_held, 0);
    check("rst_space", space_held, 0);
    check("rst_duck", duck_held, 0);
    check("rst_jump", jump_pulse, 0);
    check("rst_start", start_pulse, 0);
    check("rst_pt", prefix_timeout, 0);

    // Reset mid-sequence discards the E0 prefix
    send(8'hE0);
    check("mid_ext_state", state_dbg, 1);
    reset = 1'b1;
    idle_cycle();
    reset = 1'b0;
    check("mid_rst_state", state_dbg, 0);
    send(8'h75);
    check("mid_up", up_held, 1);
    check("mid_state", state_dbg, 0);
    check("mid_pt", prefix_timeout, 0);
    send(8'hF0); send(8'h75);
    check("mid_up_rel", up_held, 0);

    // Make with typematic repeats, then break
    send(8'h75);
    check("tm_jump1", jump_pulse, 1);
    check("tm_up1", up_held, 1);
    send(8'h75);
    check("tm_jump2", jump_pulse, 0);
    send(8'h75);
    check("tm_jump3", jump_pulse, 0);
    send(8'hF0);
    check("tm_brk_state", state_dbg, 2);
    check("tm_up_still", up_held, 1);
    send(8'h75);
    check("tm_up_rel", up_held, 0);
    check("tm_jump4", jump_pulse, 0);
    check("tm_state", state_dbg, 0);

    // Extended DOWN make and break
    send(8'hE0);
    check("ex_s1", state_dbg, 1);
    send(8'h72);
    check("ex_s0", state_dbg, 0);
    check("ex_duck1", duck_held, 1);
    send(8'hE0);
    check("ex_s1b", state_dbg, 1);
    send(8'hF0);
    check("ex_s3", state_dbg, 3);
    send(8'h72);
    check("ex_s0b", state_dbg, 0);
    check("ex_duck0", duck_held, 0);

    // Jump has priority over duck
    send(8'h72);
    check("pr_duck1", duck_held, 1);
    send(8'h29);
    check("pr_jump", jump_pulse, 1);
    check("pr_space", space_held, 1);
    check("pr_duck0", duck_held, 0);
    idle_cycle();
    check("pr_jump_end", jump_pulse, 0);
    send(8'hF0); send(8'h29);
    check("pr_duck_back", duck_held, 1);
    send(8'hF0); send(8'h72);
    check("pr_duck_off", duck_held, 0);

    // Start versus jump
    game_over = 1'b1;
    send(8'h29);
    check("st_start", start_pulse, 1);
    check("st_nojump", jump_pulse, 0);
    idle_cycle();
    check("st_start_end", start_pulse, 0);
    send(8'hF0); send(8'h29);
    check("st_space_rel", space_held, 0);
    game_over = 1'b0;
    send(8'h29);
    check("st_jump", jump_pulse, 1);
    check("st_nostart", start_pulse, 0);
    idle_cycle();
    check("st_jump_end", jump_pulse, 0);
    send(8'hF0); send(8'h29);

    // Prefix timeout after F0 with no follow-up byte
    send(8'hF0);
    for (int i = 1; i <= 15; i++) idle_cycle();
    check("to_pt_early", prefix_timeout, 0);
    check("to_state_early", state_dbg, 2);
    idle_cycle();
    check("to_pt", prefix_timeout, 1);
    check("to_state", state_dbg, 0);
    idle_cycle();
    check("to_pt_end", prefix_timeout, 0);
    send(8'h75);
    check("to_up", up_held, 1);
    check("to_jump", jump_pulse, 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
